rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback sources:
//  ALU and LSU (load data).
//  - Each source presents {rd, data} with a valid/ready handshake.
//  - Grants use round-robin priority.
//  - Drives registered wen/rdest_addr/wdata straight into the 32x32 register file.
//  - Counts contention cycles for performance debug.
// PARAMETERS
//  DATA_W  32  writeback data width
//  ADDR_W  5   register address width
//  CNT_W   16  width of saturating contention counter
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst_n        in   1       asynchronous active-low reset
//  alu_valid    in   1       ALU has a writeback pending
//  alu_rd       in   ADDR_W  ALU destination register
//  alu_data     in   DATA_W  ALU result
//  alu_ready    out  1       ALU request accepted this cycle
//  lsu_valid    in   1       LSU has a writeback pending
//  lsu_rd       in   ADDR_W  LSU destination register
//  lsu_data     in   DATA_W  LSU load data
//  lsu_ready    out  1       LSU request accepted this cycle
//  wb_hold      in   1       pipeline hold: no grants while high
//  wen          out  1       register-file write enable (registered)
//  rdest_addr   out  ADDR_W  register-file write address (registered)
//  wdata        out  DATA_W  register-file write data (registered)
//  conflict_cnt out  CNT_W   cycles both requesters were valid and one waited
// BEHAVIOUR
//  Reset, asynchronous on rst_n low:
//   - wen=0, rdest_addr=0, wdata=0, conflict_cnt=0.
//   - prio=ALU, i.e. ALU wins the next tie.
//   - Assertion mid-operation drops wen immediately; an in-flight write is lost.
//  Handshake:
//   - Requester holds valid/rd/data stable until it sees ready high.
//   - Transfer occurs in any cycle where valid & ready are both high.
//  Grant logic (combinational ready):
//   - wb_hold=1: alu_ready=lsu_ready=0.
//   - Only one source valid: it gets ready.
//   - Both valid: the source selected by prio gets ready; the other waits.
//   - At most one ready high per cycle.
//  Priority register:
//   - Updated on each grant; points to the source NOT granted.
//   - No grant: prio unchanged.
//  Write port, one-cycle latency:
//   - Grant in cycle N: at posedge ending N, wen<=(granted_rd!=0), rdest_addr<=granted_rd,
//     wdata<=granted_data.
//   - Register file commits at the following posedge.
//   - No grant: wen<=0; rdest_addr/wdata hold their previous values.
//  rd==0 requests:
//   - Accepted normally (ready high, prio updated) but produce wen=0, so x0 is never written.
//  Same rd from both sources in one cycle:
//   - No merging; served in prio order on consecutive grants, so the later write wins.
//  conflict_cnt:
//   - +1 on each cycle with alu_valid & lsu_valid & !wb_hold.
//   - Saturates at 2^CNT_W-1, no wrap.
//   - Cleared only by reset.
//  Throughput: one write per cycle sustained; no back-to-back starvation under round-robin.
//  No internal FSM states beyond prio (ALU/LSU) and the output pipeline register.
// TESTING
//  1. Reset, then ALU only: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle
//     -> alu_ready=1 that cycle; next cycle wen=1, rdest_addr=5, wdata=0xDEADBEEF; then wen=0.
//  2. Both valid continuously for 4 cycles (ALU rd=1/data=0x11, LSU rd=2/data=0x22)
//     -> grants ALU,LSU,ALU,LSU; wen rdest_addr sequence 1,2,1,2; conflict_cnt=4.
//  3. LSU valid with rd=0, data=0xFFFF_FFFF -> lsu_ready=1; next cycle wen=0; prio flips to ALU.
//  4. wb_hold=1 for 3 cycles with both valid -> no ready, wen=0, conflict_cnt unchanged;
//     after release, ALU (prio after reset) granted first.
//  5. Reset mid-operation: assert rst_n=0 mid-cycle while wen=1
//     -> wen,rdest_addr,wdata,conflict_cnt go 0 without a clock edge; first tie after release
//     grants ALU.
//  6. CNT_W=2 build, both valid 6 cycles -> conflict_cnt saturates at 3 and stays 3.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU and LSU
// writeback sources, with a registered write port and a saturating contention counter.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    input  logic              wb_hold,
    output logic              wen,
    output logic [ADDR_W-1:0] rdest_addr,
    output logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic PRIO_ALU = 1'b0;
    localparam logic PRIO_LSU = 1'b1;

    logic              prio_q, prio_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] rdest_addr_q, rdest_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;
    logic              grant_alu, grant_lsu, contend;

    // Grant stage: combinational ready, at most one source per cycle
    always_comb begin
        contend   = alu_valid && lsu_valid && !wb_hold;
        grant_alu = !wb_hold && alu_valid && (!lsu_valid || (prio_q == PRIO_ALU));
        grant_lsu = !wb_hold && lsu_valid && (!alu_valid || (prio_q == PRIO_LSU));

        prio_d         = prio_q;
        wen_d          = 1'b0;
        rdest_addr_d   = rdest_addr_q;
        wdata_d        = wdata_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant_alu) begin
            prio_d       = PRIO_LSU;
            wen_d        = (alu_rd != '0);
            rdest_addr_d = alu_rd;
            wdata_d      = alu_data;
        end else if (grant_lsu) begin
            prio_d       = PRIO_ALU;
            wen_d        = (lsu_rd != '0);
            rdest_addr_d = lsu_rd;
            wdata_d      = lsu_data;
        end

        // Saturate rather than wrap so a long stall stays visible
        if (contend && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Write-port stage: registered outputs feeding the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q         <= PRIO_ALU;
            wen_q          <= 1'b0;
            rdest_addr_q   <= '0;
            wdata_q        <= '0;
            conflict_cnt_q <= '0;
        end else begin
            prio_q         <= prio_d;
            wen_q          <= wen_d;
            rdest_addr_q   <= rdest_addr_d;
            wdata_q        <= wdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign alu_ready    = grant_alu;
    assign lsu_ready    = grant_lsu;
    assign wen          = wen_q;
    assign rdest_addr   = rdest_addr_q;
    assign wdata        = wdata_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a default build plus a CNT_W=2 build sharing the same stimulus.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        wb_hold;
    logic        wen;
    logic [4:0]  rdest_addr;
    logic [31:0] wdata;
    logic [15:0] conflict_cnt;

    logic        s_alu_ready, s_lsu_ready, s_wen;
    logic [4:0]  s_rdest_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_conflict_cnt;

    int checks   = 0;
    int failures = 0;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wb_hold(wb_hold), .wen(wen), .rdest_addr(rdest_addr), .wdata(wdata),
        .conflict_cnt(conflict_cnt)
    );

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(s_alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(s_lsu_ready),
        .wb_hold(wb_hold), .wen(s_wen), .rdest_addr(s_rdest_addr), .wdata(s_wdata),
        .conflict_cnt(s_conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        wb_hold   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wen, rdest_addr, wdata, conflict_cnt} !== 54'd0) begin
            failures++;
            $display("FAIL reset_outputs got wen=%b rd=%0d wdata=%h cnt=%0d exp all zero",
                     wen, rdest_addr, wdata, conflict_cnt);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({alu_ready, lsu_ready, wen} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got ready=%b%b wen=%b exp 000", alu_ready, lsu_ready, wen);
        end
    endtask

    task automatic test_alu_only();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            failures++;
            $display("FAIL alu_only_ready got %b%b exp 10", alu_ready, lsu_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if ({wen, rdest_addr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL alu_only_write got wen=%b rd=%0d wdata=%h exp 1/5/deadbeef", wen, rdest_addr, wdata);
        end
        tick();
        checks++;
        if ({wen, rdest_addr, wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL alu_only_idle got wen=%b rd=%0d wdata=%h exp 0/5/deadbeef (held)", wen, rdest_addr, wdata);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_alu;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            exp_alu  = (i % 2 == 0);
            exp_rd   = exp_alu ? 5'd1 : 5'd2;
            exp_data = exp_alu ? 32'h11 : 32'h22;
            #1;
            checks++;
            if ({alu_ready, lsu_ready} !== {exp_alu, !exp_alu}) begin
                failures++;
                $display("FAIL rr_ready[%0d] got %b%b exp %b%b", i, alu_ready, lsu_ready, exp_alu, !exp_alu);
            end
            tick();
            checks++;
            if ({wen, rdest_addr, wdata} !== {1'b1, exp_rd, exp_data}) begin
                failures++;
                $display("FAIL rr_write[%0d] got wen=%b rd=%0d wdata=%h exp 1/%0d/%h",
                         i, wen, rdest_addr, wdata, exp_rd, exp_data);
            end
        end
        idle_inputs();
        checks++;
        if (conflict_cnt !== 16'd4) begin
            failures++;
            $display("FAIL rr_conflict_cnt got %0d exp 4", conflict_cnt);
        end
        checks++;
        if (s_conflict_cnt !== 2'd3) begin
            failures++;
            $display("FAIL rr_conflict_cnt_small got %0d exp 3", s_conflict_cnt);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        tick();
        idle_inputs();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if ({alu_ready, lsu_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rd0_ready got %b%b exp 01", alu_ready, lsu_ready);
        end
        tick();
        lsu_valid = 1'b0;
        checks++;
        if (wen !== 1'b0) begin
            failures++;
            $display("FAIL rd0_no_write got wen=%b exp 0", wen);
        end
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
        #1;
        checks++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rd0_prio_flip got %b%b exp 10", alu_ready, lsu_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        wb_hold   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({alu_ready, lsu_ready} !== 2'b00) begin
                failures++;
                $display("FAIL hold_ready[%0d] got %b%b exp 00", i, alu_ready, lsu_ready);
            end
            tick();
            checks++;
            if ({wen, conflict_cnt} !== 17'd0) begin
                failures++;
                $display("FAIL hold_state[%0d] got wen=%b cnt=%0d exp 0/0", i, wen, conflict_cnt);
            end
        end
        wb_hold = 1'b0;
        #1;
        checks++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            failures++;
            $display("FAIL hold_release_ready got %b%b exp 10", alu_ready, lsu_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if ({wen, rdest_addr, conflict_cnt} !== {1'b1, 5'd1, 16'd1}) begin
            failures++;
            $display("FAIL hold_release_write got wen=%b rd=%0d cnt=%0d exp 1/1/1", wen, rdest_addr, conflict_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h5678;
        tick();
        checks++;
        if ({wen, rdest_addr, wdata, conflict_cnt} !== {1'b1, 5'd7, 32'h1234, 16'd1}) begin
            failures++;
            $display("FAIL midrst_pre got wen=%b rd=%0d wdata=%h cnt=%0d exp 1/7/1234/1",
                     wen, rdest_addr, wdata, conflict_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wen, rdest_addr, wdata, conflict_cnt} !== 54'd0) begin
            failures++;
            $display("FAIL midrst_async got wen=%b rd=%0d wdata=%h cnt=%0d exp all zero",
                     wen, rdest_addr, wdata, conflict_cnt);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAA;
        #1;
        checks++;
        if ({alu_ready, lsu_ready} !== 2'b10) begin
            failures++;
            $display("FAIL midrst_first_tie got %b%b exp 10", alu_ready, lsu_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (s_conflict_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL sat_cnt_small[%0d] got %0d exp %0d", i, s_conflict_cnt, exp_cnt);
            end
        end
        idle_inputs();
        checks++;
        if (conflict_cnt !== 16'd6) begin
            failures++;
            $display("FAIL sat_cnt_wide got %0d exp 6", conflict_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_round_robin();
        test_rd_zero();
        test_hold();
        test_reset_mid_op();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
